// File: rtl/base_tempo_pkg.sv
// Shared timing defaults for the irrigation timebase and its state machine.
package base_tempo_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int TICK_DIV_DEF    = 50_000_000;
  localparam int LONG_TICKS_DEF  = 15;
  localparam int DEB_CYCLES_DEF  = 1_000_000;

  // Conditioned input lanes, in bit order of cond_in_t.
  localparam int NUM_IN    = 4;
  localparam int IDX_BOTAO = 0;
  localparam int IDX_US    = 1;
  localparam int IDX_UA    = 2;
  localparam int IDX_T     = 3;

  typedef struct packed {
    logic t;
    logic ua;
    logic us;
    logic botao;
  } cond_in_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/filtro_entrada.sv
// Two-flop synchronizer followed by a stable-run debounce filter.
// Exposes the next accepted level so the parent can register it and detect
// edges in the same cycle the level changes.
module filtro_entrada
  import base_tempo_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl_nxt
);

  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic          lvl;
  logic [CW-1:0] cnt, cnt_nxt;

  // Count consecutive samples that disagree with the accepted level; the
  // DEB_CYCLES-th disagreeing sample flips the level and restarts the count.
  always_comb begin
    lvl_nxt = lvl;
    cnt_nxt = '0;
    if (sync[1] != lvl) begin
      if (cnt == CNT_LAST) lvl_nxt = sync[1];
      else                 cnt_nxt = cnt + 1'b1;
    end
  end

  // Synchronizer, accepted level and run counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      lvl  <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], din};
      lvl  <= lvl_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule

// File: rtl/base_tempo.sv
// Step/long tick generator plus conditioned button and sensor inputs.
// All outputs are flops; tick outputs are computed one edge ahead so that a
// button pulse can suppress a coincident tick in the very same cycle.
module base_tempo
  import base_tempo_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       botao_in,
  input  logic       Us_in,
  input  logic       Ua_in,
  input  logic       T_in,
  output logic       sinal,
  output logic       sinal15,
  output logic       botao,
  output logic       Us,
  output logic       Ua,
  output logic       T,
  output logic [3:0] cont15
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    LT_LAST  = 4'(LONG_TICKS - 1);

  cond_in_t          raw;
  logic [NUM_IN-1:0] lvl_nxt, lvl_q;
  logic [PW-1:0]     pre, pre_nxt;
  logic [3:0]        c15_nxt;
  logic              press_nxt, sinal_nxt, s15_nxt;

  assign raw = '{t: T_in, ua: Ua_in, us: Us_in, botao: botao_in};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_filt
    filtro_entrada #(.DEB_CYCLES(DEB_CYCLES)) u_filt (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (raw[i]),
      .lvl_nxt (lvl_nxt[i])
    );
  end

  // Next counter values and lookahead tick/press decisions. A registered
  // button pulse clears both counters on the following edge.
  always_comb begin
    press_nxt = lvl_nxt[IDX_BOTAO] & ~lvl_q[IDX_BOTAO];
    pre_nxt   = (botao || pre == PRE_LAST) ? '0 : pre + 1'b1;
    c15_nxt   = cont15;
    if (botao)      c15_nxt = '0;
    else if (sinal) c15_nxt = (cont15 == LT_LAST) ? 4'd0 : cont15 + 4'd1;
    sinal_nxt = (pre_nxt == PRE_LAST) && !press_nxt;
    s15_nxt   = sinal_nxt && (c15_nxt == LT_LAST);
  end

  // Counters, tick outputs, accepted levels and the press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre     <= '0;
      cont15  <= '0;
      sinal   <= 1'b0;
      sinal15 <= 1'b0;
      botao   <= 1'b0;
      lvl_q   <= '0;
    end else begin
      pre     <= pre_nxt;
      cont15  <= c15_nxt;
      sinal   <= sinal_nxt;
      sinal15 <= s15_nxt;
      botao   <= press_nxt;
      lvl_q   <= lvl_nxt;
    end
  end

  assign Us = lvl_q[IDX_US];
  assign Ua = lvl_q[IDX_UA];
  assign T  = lvl_q[IDX_T];

endmodule

// File: tb/tb_base_tempo.sv
// Bench for base_tempo: directed table, hand-written corner sequences and
// randomized inputs against a behavioural model.
module tb_base_tempo;

  localparam int TD  = 4;
  localparam int LT  = 3;
  localparam int DEB = 3;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       botao_in = 1'b0, Us_in = 1'b0, Ua_in = 1'b0, T_in = 1'b0;
  logic       sinal, sinal15, botao, Us, Ua, T;
  logic [3:0] cont15;

  base_tempo #(.TICK_DIV(TD), .LONG_TICKS(LT), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .botao_in(botao_in), .Us_in(Us_in),
    .Ua_in(Ua_in), .T_in(T_in), .sinal(sinal), .sinal15(sinal15),
    .botao(botao), .Us(Us), .Ua(Ua), .T(T), .cont15(cont15)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  // Model: t = cycles since the last restart (reset release or button
  // clear); each input is accepted once its synced value has been stable at
  // a new level for DEB consecutive samples.
  int t;
  bit mlvl[4], d1[4], d2[4], last[4];
  int run[4];
  bit m_botao;

  task automatic mreset();
    t = 0; m_botao = 0;
    for (int i = 0; i < 4; i++) begin
      mlvl[i] = 0; d1[i] = 0; d2[i] = 0; last[i] = 0; run[i] = 0;
    end
  endtask

  task automatic model_edge(input bit [3:0] r);
    bit prev;
    bit samp;
    prev = mlvl[0];
    if (m_botao) t = 0; else t++;
    for (int i = 0; i < 4; i++) begin
      samp = d2[i]; d2[i] = d1[i]; d1[i] = r[i];
      if (samp == last[i]) run[i]++;
      else begin run[i] = 1; last[i] = samp; end
      if (samp != mlvl[i] && run[i] >= DEB) mlvl[i] = samp;
    end
    m_botao = mlvl[0] && !prev;
  endtask

  function automatic logic [9:0] expv();
    bit s, s15;
    int c;
    c   = (t / TD) % LT;
    s   = !m_botao && (t % TD == TD - 1);
    s15 = s && (c == LT - 1);
    return {s, s15, m_botao, mlvl[1], mlvl[2], mlvl[3], 4'(c)};
  endfunction

  function automatic logic [9:0] outv();
    return {sinal, sinal15, botao, Us, Ua, T, cont15};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", nm, act, exp, t, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge({T_in, Ua_in, Us_in, botao_in});
    #1;
    check("model", 32'(outv()), 32'(expv()));
  endtask

  // Asynchronous reset asserted mid-cycle, held over one edge, released on
  // a falling edge.
  task automatic areset();
    #2 rst_n = 1'b0;
    mreset();
    #1 check("rst_now", 32'(outv()), 32'h0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_rst", 32'(outv()), 32'(expv()));
  endtask

  typedef struct {
    logic       s;
    logic       s15;
    logic [3:0] c;
  } tv_t;
  tv_t tab[13];

  initial begin
    int n, pn, sn, pulses, cat;
    bit seen;
    bit [5:0] bounce;

    // Cycles 1..13 after release with idle inputs.
    tab[0]  = '{0, 0, 0}; tab[1]  = '{0, 0, 0}; tab[2]  = '{0, 0, 0};
    tab[3]  = '{1, 0, 0}; tab[4]  = '{0, 0, 1}; tab[5]  = '{0, 0, 1};
    tab[6]  = '{0, 0, 1}; tab[7]  = '{1, 0, 1}; tab[8]  = '{0, 0, 2};
    tab[9]  = '{0, 0, 2}; tab[10] = '{0, 0, 2}; tab[11] = '{1, 1, 2};
    tab[12] = '{0, 0, 0};

    mreset();
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) step();
      check($sformatf("tab%0d", c + 1), 32'({sinal, sinal15, cont15}),
            32'({tab[c].s, tab[c].s15, tab[c].c}));
    end

    // Reset in the middle of a count (pre=2, cont15=2).
    for (int i = 0; i < 40 && t != 22; i++) step();
    check("pre_before_rst", 32'(dut.pre), 32'd2);
    check("c15_before_rst", 32'(cont15), 32'd2);
    areset();
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (sinal) begin n = i; break; end
    end
    check("first_sinal_edges", 32'(n), 32'd3);
    check("first_sinal_c15", 32'(cont15), 32'd0);

    // Sensor latency.
    Us_in = 1'b1;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (Us) begin n = i; break; end
    end
    check("us_latency", 32'(n), 32'd5);

    // Two-cycle glitch never reaches the output.
    Ua_in = 1'b1; seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) Ua_in = 1'b0;
      step();
      seen |= Ua;
    end
    check("ua_glitch", 32'(seen), 32'd0);

    // Button held 10 cycles: one pulse, resync of the timebase.
    pn = 0; sn = 0; pulses = 0; cat = -1;
    for (int i = 1; i <= 25; i++) begin
      botao_in = (i <= 10);
      step();
      if (botao) begin pulses++; if (pn == 0) pn = i; end
      if (sinal && pn > 0 && sn == 0) begin sn = i; cat = cont15; end
    end
    check("btn_pulses", 32'(pulses), 32'd1);
    check("btn_latency", 32'(pn), 32'd5);
    check("btn_to_sinal", 32'(sn - pn), 32'd4);
    check("btn_sinal_c15", 32'(cat), 32'd0);

    // Button pulse landing on the prescaler terminal count.
    for (int i = 0; i < 10 && (t % TD) != 2; i++) step();
    botao_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("align_botao", 32'(botao), 32'd1);
    check("align_pre", 32'(dut.pre), 32'(TD - 1));
    check("align_sinal", 32'(sinal), 32'd0);
    step();
    check("align_pre_clr", 32'(dut.pre), 32'd0);
    check("align_c15_clr", 32'(cont15), 32'd0);
    botao_in = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Bouncing T input.
    bounce = 6'b111101;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      T_in = (i <= 6) ? bounce[i-1] : 1'b1;
      step();
      if (T && n < 0) n = i;
    end
    check("t_bounce", 32'(n), 32'd7);

    // Randomized inputs with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) Us_in = ~Us_in;
      if ($urandom_range(2) == 0) Ua_in = ~Ua_in;
      if ($urandom_range(4) == 0) T_in = ~T_in;
      if ($urandom_range(6) == 0) botao_in = ~botao_in;
      if ($urandom_range(199) == 0) areset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
